// File: rtl/rv_iommu_irq_gen_pkg.sv
// Shared definitions for the IOMMU interrupt generator: source indices,
// MSI sequencer states and the vector-index width helper.
package rv_iommu_irq_gen_pkg;

  localparam int IRQ_CQ  = 0;
  localparam int IRQ_FQ  = 1;
  localparam int IRQ_HPM = 2;
  localparam int IRQ_PQ  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } msi_state_e;

  function automatic int calc_vec_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv_iommu_irq_gen_rr_arb.sv
// Combinational round-robin pick: lowest requesting index at or above ptr_i,
// wrapping around to index 0.
module rv_iommu_rr_arb
  import rv_iommu_irq_gen_pkg::*;
#(
  parameter  int N = 16,
  localparam int W = calc_vec_w(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] gnt_idx_o,
  output logic         gnt_valid_o
);

  int idx;

  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = W'(idx);
      end
    end
  end

endmodule

// File: rtl/rv_iommu_irq_gen.sv
// IOMMU interrupt generator: maps sources to vectors, then drives level WSI
// wires or issues one-at-a-time MSI writes from the per-vector table.
module rv_iommu_irq_gen
  import rv_iommu_irq_gen_pkg::*;
#(
  parameter  int N_SRC      = 4,
  parameter  int N_INT_VEC  = 16,
  parameter  int ADDR_WIDTH = 64,
  localparam int VEC_W      = calc_vec_w(N_INT_VEC)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            wsi_mode_i,
  input  logic [N_SRC-1:0]                src_pend_i,
  input  logic [N_SRC-1:0]                src_ie_i,
  input  logic [N_SRC*VEC_W-1:0]          icvec_i,
  input  logic [N_INT_VEC*ADDR_WIDTH-1:0] msi_addr_i,
  input  logic [N_INT_VEC*32-1:0]         msi_data_i,
  input  logic [N_INT_VEC-1:0]            msi_mask_i,
  output logic [N_INT_VEC-1:0]            wsi_wires_o,
  output logic                            msi_valid_o,
  input  logic                            msi_ready_i,
  output logic [ADDR_WIDTH-1:0]           msi_addr_o,
  output logic [31:0]                     msi_data_o,
  input  logic                            msi_done_i,
  input  logic                            msi_err_i,
  output logic                            msi_err_o
);

  // MSI handshake: a request is offered while msi_valid_o=1 with address/data
  // stable, and is taken on the first cycle with msi_ready_i=1; the response is
  // the single cycle with msi_done_i=1 (msi_err_i qualified by it).

  logic [N_SRC-1:0]      act, act_q, rise;
  logic [VEC_W-1:0]      src_vec [N_SRC];
  logic [VEC_W-1:0]      raw_vec;
  logic [N_INT_VEC-1:0]  vpend_q, vpend_d, wsi_q, wsi_d, elig;
  msi_state_e            state_q, state_d;
  logic [VEC_W-1:0]      ptr_q, ptr_d, sel_q, sel_d, gnt_idx;
  logic                  gnt_valid;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;

  assign act  = src_pend_i & src_ie_i;
  assign rise = act & ~act_q;
  assign elig = vpend_q & ~msi_mask_i;

  // Out-of-range vector indices collapse onto the last vector.
  always_comb begin
    raw_vec = '0;
    for (int s = 0; s < N_SRC; s++) begin
      raw_vec    = icvec_i[s*VEC_W +: VEC_W];
      src_vec[s] = (int'(raw_vec) >= N_INT_VEC) ? VEC_W'(N_INT_VEC - 1) : raw_vec;
    end
  end

  always_comb begin
    wsi_d = '0;
    if (wsi_mode_i) begin
      for (int s = 0; s < N_SRC; s++) begin
        if (act[s]) wsi_d[src_vec[s]] = 1'b1;
      end
    end
  end

  // Clear first, then set, so a coincident new edge keeps the vector pending.
  always_comb begin
    vpend_d = vpend_q;
    if (state_q == REQ && msi_ready_i) vpend_d[sel_q] = 1'b0;
    for (int s = 0; s < N_SRC; s++) begin
      if (rise[s]) vpend_d[src_vec[s]] = 1'b1;
    end
    if (wsi_mode_i) vpend_d = '0;
  end

  rv_iommu_rr_arb #(.N(N_INT_VEC)) u_arb (
    .req_i      (elig),
    .ptr_i      (ptr_q),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (!wsi_mode_i && gnt_valid) begin
          sel_d       = gnt_idx;
          addr_d      = msi_addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          addr_d[1:0] = 2'b00;
          data_d      = msi_data_i[int'(gnt_idx)*32 +: 32];
          state_d     = REQ;
        end
      end
      REQ: begin
        if (msi_ready_i) begin
          ptr_d   = (int'(sel_q) == N_INT_VEC - 1) ? '0 : sel_q + 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (msi_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q   <= '0;
      vpend_q <= '0;
      wsi_q   <= '0;
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      act_q   <= act;
      vpend_q <= vpend_d;
      wsi_q   <= wsi_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign wsi_wires_o = wsi_q;
  assign msi_valid_o = (state_q == REQ);
  assign msi_addr_o  = addr_q;
  assign msi_data_o  = data_q;
  assign msi_err_o   = (state_q == RESP) && msi_done_i && msi_err_i;

endmodule

// File: tb/tb_rv_iommu_irq_gen.sv
// Directed bench for rv_iommu_irq_gen: WSI level path, MSI issue, masking,
// round-robin order, back-pressure, error pulse and mode switch.
module tb_rv_iommu_irq_gen;

  localparam int NS = 4;
  localparam int NV = 16;
  localparam int AW = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wsi_mode;
  logic [NS-1:0]  src_pend;
  logic [NS-1:0]  src_ie;
  logic [NS*4-1:0] icvec;
  logic [NV*AW-1:0] msi_addr_tbl;
  logic [NV*32-1:0] msi_data_tbl;
  logic [NV-1:0]  msi_mask;
  logic [NV-1:0]  wsi_wires;
  logic           msi_valid;
  logic           msi_ready;
  logic [AW-1:0]  msi_addr;
  logic [31:0]    msi_data;
  logic           msi_done;
  logic           msi_err_in;
  logic           msi_err_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_iommu_irq_gen #(.N_SRC(NS), .N_INT_VEC(NV), .ADDR_WIDTH(AW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wsi_mode_i (wsi_mode),
    .src_pend_i (src_pend),
    .src_ie_i   (src_ie),
    .icvec_i    (icvec),
    .msi_addr_i (msi_addr_tbl),
    .msi_data_i (msi_data_tbl),
    .msi_mask_i (msi_mask),
    .wsi_wires_o(wsi_wires),
    .msi_valid_o(msi_valid),
    .msi_ready_i(msi_ready),
    .msi_addr_o (msi_addr),
    .msi_data_o (msi_data),
    .msi_done_i (msi_done),
    .msi_err_i  (msi_err_in),
    .msi_err_o  (msi_err_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_icvec(input int s, input logic [3:0] v);
    icvec[s*4 +: 4] = v;
  endtask

  task automatic set_vec(input int v, input logic [63:0] a, input logic [31:0] d);
    msi_addr_tbl[v*AW +: AW] = a;
    msi_data_tbl[v*32 +: 32] = d;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (msi_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(msi_valid), 64'd1);
  endtask

  task automatic resp_phase(input string tag, input logic err);
    msi_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(msi_valid), 64'd0);
    msi_done   = 1'b1;
    msi_err_in = err;
    #1;
    check({tag, "_err_pulse"}, 64'(msi_err_out), 64'(err));
    @(negedge clk);
    msi_done   = 1'b0;
    msi_err_in = 1'b0;
    #1;
    check({tag, "_err_low"}, 64'(msi_err_out), 64'd0);
  endtask

  task automatic do_msi(input string tag, input logic [63:0] ea, input logic [31:0] ed,
                        input logic err);
    wait_valid(tag);
    check({tag, "_addr"}, msi_addr, ea);
    check({tag, "_data"}, 64'(msi_data), 64'(ed));
    msi_ready = 1'b1;
    @(negedge clk);
    resp_phase(tag, err);
  endtask

  task automatic no_valid(input string tag, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (msi_valid === 1'b1) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    wsi_mode     = 1'b1;
    src_pend     = '0;
    src_ie       = '0;
    icvec        = '0;
    msi_addr_tbl = '0;
    msi_data_tbl = '0;
    msi_mask     = '0;
    msi_ready    = 1'b0;
    msi_done     = 1'b0;
    msi_err_in   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wires", 64'(wsi_wires), 64'd0);
    check("rst_valid", 64'(msi_valid), 64'd0);
    check("rst_addr", msi_addr, 64'd0);
    check("rst_data", 64'(msi_data), 64'd0);
    check("rst_err", 64'(msi_err_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: WSI level path, CQ and FQ both on vector 2
    set_icvec(0, 4'd2);
    set_icvec(1, 4'd2);
    src_ie = 4'b0011;
    src_pend[0] = 1'b1;
    #1;
    check("t1_latency", 64'(wsi_wires), 64'd0);
    @(negedge clk);
    check("t1_cq_high", 64'(wsi_wires), 64'h0004);
    src_pend[1] = 1'b1;
    src_pend[0] = 1'b0;
    @(negedge clk);
    check("t1_fq_holds", 64'(wsi_wires), 64'h0004);
    src_pend[1] = 1'b0;
    @(negedge clk);
    check("t1_fall", 64'(wsi_wires), 64'h0000);
    check("t1_no_msi", 64'(msi_valid), 64'd0);

    // 2: single MSI, address low bits dropped
    wsi_mode = 1'b0;
    set_icvec(1, 4'd5);
    set_vec(5, 64'h8000_1003, 32'h0000_ABCD);
    @(negedge clk);
    check("t2_wires_off", 64'(wsi_wires), 64'd0);
    src_pend[1] = 1'b1;
    do_msi("t2", 64'h8000_1000, 32'h0000_ABCD, 1'b0);
    check("t2_vpend5", 64'(dut.vpend_q[5]), 64'd0);
    no_valid("t2_single", 6);

    // 3: masked vector waits, fires once unmasked
    src_pend[1] = 1'b0;
    msi_mask[3] = 1'b1;
    set_icvec(0, 4'd3);
    set_vec(3, 64'h0000_0000_FEE0_0012, 32'h0000_0033);
    src_pend[0] = 1'b1;
    no_valid("t3_masked", 20);
    check("t3_vpend3", 64'(dut.vpend_q[3]), 64'd1);
    msi_mask[3] = 1'b0;
    do_msi("t3", 64'h0000_0000_FEE0_0010, 32'h0000_0033, 1'b0);
    no_valid("t3_single", 6);
    src_pend[0] = 1'b0;
    @(negedge clk);

    // reset mid-request drops valid at once
    set_icvec(0, 4'd1);
    set_vec(1, 64'h1000_0010, 32'h0000_0101);
    src_pend[0] = 1'b1;
    wait_valid("rst_mid");
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(msi_valid), 64'd0);
    src_pend = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_addr", msi_addr, 64'd0);

    // 4: round-robin order from pointer 0, then again after wrap
    src_ie = 4'b0111;
    set_icvec(1, 4'd4);
    set_icvec(2, 4'd7);
    set_vec(4, 64'h1000_0040, 32'h0000_0104);
    set_vec(7, 64'h1000_0070, 32'h0000_0107);
    @(negedge clk);
    src_pend = 4'b0111;
    do_msi("t4a_v1", 64'h1000_0010, 32'h0000_0101, 1'b0);
    do_msi("t4a_v4", 64'h1000_0040, 32'h0000_0104, 1'b0);
    do_msi("t4a_v7", 64'h1000_0070, 32'h0000_0107, 1'b0);
    src_pend = '0;
    repeat (2) @(negedge clk);
    src_pend = 4'b0111;
    do_msi("t4b_v1", 64'h1000_0010, 32'h0000_0101, 1'b0);
    do_msi("t4b_v4", 64'h1000_0040, 32'h0000_0104, 1'b0);
    do_msi("t4b_v7", 64'h1000_0070, 32'h0000_0107, 1'b0);
    no_valid("t4_done", 6);
    src_pend = '0;
    @(negedge clk);

    // 5: back-pressure; re-edge coincident with accept yields a second write
    set_icvec(1, 4'd9);
    set_vec(9, 64'hDEAD_BEEF_0000_0906, 32'h0000_9999);
    src_pend[1] = 1'b1;
    wait_valid("t5");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_hold_valid", 64'(msi_valid), 64'd1);
      check("t5_hold_addr", msi_addr, 64'hDEAD_BEEF_0000_0904);
      check("t5_hold_data", 64'(msi_data), 64'h9999);
      if (i == 2) src_pend[1] = 1'b0;
      if (i == 6) set_vec(9, 64'hDEAD_BEEF_0000_0A01, 32'h0000_9999);
    end
    msi_ready   = 1'b1;
    src_pend[1] = 1'b1;
    @(negedge clk);
    check("t5_set_beats_clear", 64'(dut.vpend_q[9]), 64'd1);
    resp_phase("t5_first", 1'b0);
    do_msi("t5_second", 64'hDEAD_BEEF_0000_0A00, 32'h0000_9999, 1'b0);
    no_valid("t5_only_two", 6);

    // 6a: errored response pulses msi_err_o once
    src_pend[1] = 1'b0;
    set_icvec(0, 4'd2);
    set_vec(2, 64'h0000_2000, 32'h0000_0022);
    src_pend[0] = 1'b1;
    do_msi("t6_err", 64'h0000_2000, 32'h0000_0022, 1'b1);
    src_pend[0] = 1'b0;
    @(negedge clk);

    // 6b: switch to WSI while the request is outstanding
    set_icvec(1, 4'd6);
    set_vec(6, 64'h0000_6000, 32'h0000_0066);
    src_pend[1] = 1'b1;
    wait_valid("t6_sw");
    wsi_mode = 1'b1;
    @(negedge clk);
    check("t6_valid_kept", 64'(msi_valid), 64'd1);
    check("t6_wires_on", 64'(wsi_wires), 64'h0040);
    do_msi("t6_inflight", 64'h0000_6000, 32'h0000_0066, 1'b0);
    no_valid("t6_no_new", 6);
    check("t6_wires_hold", 64'(wsi_wires), 64'h0040);
    check("t6_vpend_clr", 64'(dut.vpend_q), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
